// File: rtl/rs_syndrome_calc.sv
// RS syndrome calculator over GF(2^8) (poly 0x11D): Horner-accumulates S_j = r(alpha^j), j=1..TWO_T,
// one symbol per clock, and publishes the syndromes plus an error flag one cycle after the last symbol.
module rs_syndrome_calc #(
  parameter int N     = 255,
  parameter int TWO_T = 16
) (
  input  logic                 clk_in,
  input  logic                 sys_rst,
  input  logic                 sync,
  input  logic [7:0]           data_in,
  output logic [8*TWO_T-1:0]   syndrome,
  output logic                 synd_valid,
  output logic                 err_detect,
  output logic                 busy
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  // With a constant operand this folds into a pure XOR network.
  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] alphaPow(input int e);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < e; i++) r = gfMul(r, 8'h02);
    return r;
  endfunction

  logic [7:0]         r_acc     [TWO_T];
  logic [7:0]         w_accNext [TWO_T];
  logic [CNT_W-1:0]   r_symCnt;
  logic [8*TWO_T-1:0] r_syndrome;
  logic [8*TWO_T-1:0] w_syndNext;
  logic               r_syndValid;
  logic               r_errDetect;
  logic               w_anyErr;

  genvar j;
  for (j = 0; j < TWO_T; j++) begin : gSynd
    localparam logic [7:0] ALPHA_J = alphaPow(j + 1);
    assign w_accNext[j]        = gfMul(r_acc[j], ALPHA_J) ^ data_in;
    assign w_syndNext[8*j +: 8] = w_accNext[j];
  end

  assign w_anyErr = |w_syndNext;

  // An abort (sync high mid-word) drops the partial word without touching published results.
  always_ff @(posedge clk_in or posedge sys_rst) begin
    if (sys_rst) begin
      r_symCnt    <= '0;
      r_syndrome  <= '0;
      r_syndValid <= 1'b0;
      r_errDetect <= 1'b0;
      for (int k = 0; k < TWO_T; k++) r_acc[k] <= 8'h00;
    end else begin
      r_syndValid <= 1'b0;
      if (!sync) begin
        if (r_symCnt == '0) begin
          for (int k = 0; k < TWO_T; k++) r_acc[k] <= data_in;
          r_symCnt <= CNT_W'(1);
        end else if (r_symCnt == LAST_CNT) begin
          r_syndrome  <= w_syndNext;
          r_errDetect <= w_anyErr;
          r_syndValid <= 1'b1;
          r_symCnt    <= '0;
        end else begin
          for (int k = 0; k < TWO_T; k++) r_acc[k] <= w_accNext[k];
          r_symCnt <= r_symCnt + CNT_W'(1);
        end
      end else begin
        r_symCnt <= '0;
      end
    end
  end

  assign syndrome   = r_syndrome;
  assign synd_valid = r_syndValid;
  assign err_detect = r_errDetect;
  assign busy       = (r_symCnt != '0);

endmodule

// File: tb/tb_rs_syndrome_calc.sv
// Scoreboard bench for rs_syndrome_calc: a table-based GF model predicts syndromes by direct
// polynomial evaluation; a negedge monitor pops and checks each synd_valid pulse and its cycle.
module tb_rs_syndrome_calc;

  localparam int N     = 255;
  localparam int TWO_T = 16;
  localparam int K     = N - TWO_T;

  logic                 clk_in = 1'b0;
  logic                 sys_rst;
  logic                 sync;
  logic [7:0]           data_in;
  logic [8*TWO_T-1:0]   syndrome;
  logic                 synd_valid;
  logic                 err_detect;
  logic                 busy;

  rs_syndrome_calc #(.N(N), .TWO_T(TWO_T)) dut (
    .clk_in     (clk_in),
    .sys_rst    (sys_rst),
    .sync       (sync),
    .data_in    (data_in),
    .syndrome   (syndrome),
    .synd_valid (synd_valid),
    .err_detect (err_detect),
    .busy       (busy)
  );

  always #5 clk_in = ~clk_in;

  int cycleCnt = 0;
  always @(posedge clk_in) cycleCnt <= cycleCnt + 1;

  typedef struct {
    logic [8*TWO_T-1:0] synd;
    logic               err;
    int                 cyc;
  } exp_t;

  exp_t expQ[$];
  exp_t monE;

  int totalChecks = 0;
  int badChecks   = 0;

  logic [7:0] expT [255];
  logic [7:0] logT [256];
  logic [7:0] gen  [17];
  logic [7:0] wordBuf [N];
  logic [8*TWO_T-1:0] heldSynd;
  logic               heldErr;

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] expv);
    totalChecks++;
    if (got !== expv) begin
      badChecks++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, expv);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return expT[(int'(logT[a]) + int'(logT[b])) % 255];
  endfunction

  function automatic void buildTables();
    logic [8:0] x;
    x = 9'h001;
    for (int i = 0; i < 255; i++) begin
      expT[i] = x[7:0];
      logT[x[7:0]] = 8'(i);
      x = {x[7:0], 1'b0};
      if (x[8]) x = x ^ 9'h11D;
    end
    logT[0] = 8'h00;
    for (int k = 0; k < 17; k++) gen[k] = 8'h00;
    gen[0] = 8'h01;
    for (int i = 1; i <= TWO_T; i++) begin
      for (int k = TWO_T; k >= 1; k--) gen[k] = gen[k-1] ^ gmul(gen[k], expT[i]);
      gen[0] = gmul(gen[0], expT[i]);
    end
  endfunction

  // Systematic encoding: message in wordBuf[0..K-1], remainder appended high degree first.
  function automatic void encodeWord();
    logic [7:0] par [TWO_T];
    logic [7:0] fb;
    for (int k = 0; k < TWO_T; k++) par[k] = 8'h00;
    for (int p = 0; p < K; p++) begin
      fb = wordBuf[p] ^ par[TWO_T-1];
      for (int k = TWO_T - 1; k >= 1; k--) par[k] = par[k-1] ^ gmul(fb, gen[k]);
      par[0] = gmul(fb, gen[0]);
    end
    for (int m = 0; m < TWO_T; m++) wordBuf[K + m] = par[TWO_T-1-m];
  endfunction

  function automatic void computeExpected(output logic [8*TWO_T-1:0] s, output logic e);
    logic [7:0] acc;
    s = '0;
    for (int j = 1; j <= TWO_T; j++) begin
      acc = 8'h00;
      for (int p = 0; p < N; p++) acc = acc ^ gmul(wordBuf[p], expT[(j * (N - 1 - p)) % 255]);
      s[8*(j-1) +: 8] = acc;
    end
    e = |s;
  endfunction

  task automatic applyStimulus(input logic s, input logic [7:0] d);
    @(posedge clk_in);
    #1;
    sync    = s;
    data_in = d;
  endtask

  task automatic sendWord(input int count);
    exp_t e;
    for (int i = 0; i < count; i++) applyStimulus(1'b0, wordBuf[i]);
    if (count == N) begin
      computeExpected(e.synd, e.err);
      e.cyc = cycleCnt + 1;
      expQ.push_back(e);
      heldSynd = e.synd;
      heldErr  = e.err;
    end
  endtask

  function automatic void fillWord(input logic [7:0] v);
    for (int i = 0; i < N; i++) wordBuf[i] = v;
  endfunction

  initial begin
    forever begin
      @(negedge clk_in);
      if (expQ.size() > 0 && !synd_valid && cycleCnt > expQ[0].cyc) begin
        monE = expQ.pop_front();
        checkOutput("missing_valid", 128'(1'b0), 128'(1'b1));
      end
      if (synd_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_valid", 128'(1'b1), 128'(1'b0));
        end else begin
          monE = expQ.pop_front();
          checkOutput("synd", 128'(syndrome), 128'(monE.synd));
          checkOutput("err", 128'(err_detect), 128'(monE.err));
          checkOutput("valid_cycle", 128'(cycleCnt), 128'(monE.cyc));
        end
      end
    end
  end

  initial begin
    sys_rst = 1'b1;
    sync    = 1'b1;
    data_in = 8'h00;
    buildTables();
    repeat (3) @(posedge clk_in);
    #1;
    checkOutput("rst_synd", 128'(syndrome), 128'(0));
    checkOutput("rst_err", 128'(err_detect), 128'(0));
    checkOutput("rst_valid", 128'(synd_valid), 128'(0));
    checkOutput("rst_busy", 128'(busy), 128'(0));
    sys_rst = 1'b0;

    $display("[TB] all-zero word");
    fillWord(8'h00);
    sendWord(N);
    applyStimulus(1'b1, 8'h00);
    checkOutput("zero_synd", 128'(syndrome), 128'(0));
    checkOutput("zero_err", 128'(err_detect), 128'(0));

    $display("[TB] single error at last position");
    fillWord(8'h00);
    wordBuf[N-1] = 8'h01;
    sendWord(N);
    applyStimulus(1'b1, 8'h00);
    checkOutput("last_pos", 128'(syndrome), {16{8'h01}});

    $display("[TB] single error at first position");
    fillWord(8'h00);
    wordBuf[0] = 8'h01;
    sendWord(N);
    applyStimulus(1'b1, 8'h00);
    checkOutput("first_pos_s1", 128'(syndrome[7:0]), 128'(8'h8E));
    checkOutput("first_pos_err", 128'(err_detect), 128'(1));

    $display("[TB] abort after 100 symbols");
    fillWord(8'h00);
    sendWord(100);
    checkOutput("busy_mid", 128'(busy), 128'(1));
    applyStimulus(1'b1, 8'h00);
    applyStimulus(1'b1, 8'h00);
    checkOutput("busy_abort", 128'(busy), 128'(0));
    checkOutput("abort_hold_synd", 128'(syndrome), 128'(heldSynd));
    checkOutput("abort_hold_err", 128'(err_detect), 128'(heldErr));
    sendWord(N);
    applyStimulus(1'b1, 8'h00);

    $display("[TB] two encoded codewords back-to-back");
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < K; i++) wordBuf[i] = 8'($urandom_range(0, 255));
      encodeWord();
      sendWord(N);
    end
    applyStimulus(1'b1, 8'h00);
    checkOutput("cw_err", 128'(err_detect), 128'(0));

    $display("[TB] codeword with 8 flipped bytes");
    for (int i = 0; i < K; i++) wordBuf[i] = 8'($urandom_range(0, 255));
    encodeWord();
    for (int k = 0; k < 8; k++) begin
      int pos;
      pos = k * 30 + int'($urandom_range(0, 29));
      wordBuf[pos] = wordBuf[pos] ^ 8'($urandom_range(1, 255));
    end
    sendWord(N);
    applyStimulus(1'b1, 8'h00);
    checkOutput("flip_err", 128'(err_detect), 128'(1));

    $display("[TB] reset mid-word");
    fillWord(8'h00);
    wordBuf[3] = 8'h5A;
    sendWord(150);
    @(posedge clk_in);
    #1;
    sys_rst = 1'b1;
    sync    = 1'b1;
    #2;
    checkOutput("mid_rst_synd", 128'(syndrome), 128'(0));
    checkOutput("mid_rst_err", 128'(err_detect), 128'(0));
    checkOutput("mid_rst_valid", 128'(synd_valid), 128'(0));
    checkOutput("mid_rst_busy", 128'(busy), 128'(0));
    repeat (2) @(posedge clk_in);
    #1;
    sys_rst = 1'b0;
    fillWord(8'h00);
    wordBuf[N-1] = 8'h01;
    sendWord(N);
    applyStimulus(1'b1, 8'h00);
    checkOutput("rst_last_pos", 128'(syndrome), {16{8'h01}});

    repeat (3) applyStimulus(1'b1, 8'h00);
    checkOutput("queue_empty", 128'(expQ.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/rs_syndrome_calc.md
# rs_syndrome_calc

First stage of the RS decoder datapath. It sits directly downstream of the channel (RS encoder output plus injected errors) and upstream of the key-equation solver. It accumulates the 2T syndromes of each received RS(N, N−2T) codeword over GF(2^8), one symbol per cycle. It presents the syndromes and an error-detected flag one cycle after the last symbol.

## Interface
- N, 255, codeword length in symbols (2T+1 ≤ N ≤ 255)
- TWO_T, 16, number of parity symbols / syndromes (2..32)

- clk_in  input  1  system clock; all state on rising edge
- sys_rst  input  1  asynchronous, active-high reset
- sync  input  1  active-low symbol strobe: data_in is a valid codeword symbol in every cycle where sync = 0
- data_in  input  8  received symbol, highest-degree coefficient r(N−1) first
- syndrome  output  8*TWO_T  S_j at bits [8j−1:8j−8], j = 1..TWO_T; held between updates
- synd_valid  output  1  one-cycle pulse: syndrome/err_detect updated for the codeword just completed
- err_detect  output  1  1 when any S_j ≠ 0 for the latest codeword
- busy  output  1  1 while a codeword is partially received (sym_cnt ≠ 0)

## Operation
- Field: GF(2^8), primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D), α = 0x02. S_j = r(α^j), j = 1..TWO_T (first consecutive root α^1).
- Per-syndrome Horner accumulator acc_j (8 bits) and a multiply-by-constant α^j network (pure XOR; constants fixed at elaboration).
- sym_cnt: 0..N−1 counter of accepted symbols in the current word.
- Idle/accumulate behaviour per rising edge:
  - sync = 0 and sym_cnt = 0: acc_j ← data_in (first symbol); sym_cnt ← 1.
  - sync = 0 and 0 < sym_cnt < N−1: acc_j ← acc_j·α^j ⊕ data_in; sym_cnt ← sym_cnt+1.
  - sync = 0 and sym_cnt = N−1 (last symbol): syndrome_j ← acc_j·α^j ⊕ data_in; err_detect ← OR-reduce of those new values; synd_valid ← 1; sym_cnt ← 0.
  - sync = 1 and sym_cnt ≠ 0: abort. Partial word discarded, sym_cnt ← 0, no synd_valid, syndrome/err_detect unchanged.
  - sync = 1 and sym_cnt = 0: hold.
- synd_valid is 0 in every cycle not following a last-symbol edge.
- Back-to-back words: the first symbol of word k+1 may arrive in the cycle immediately after the last symbol of word k. No bubble is required, and both words are processed fully.
- acc_j values are not visible outside the block; only completed words update outputs.

## Timing
- Reset (sys_rst = 1, asynchronous): syndrome = 0, err_detect = 0, synd_valid = 0, busy = 0, sym_cnt = 0, acc_j = 0. Reset mid-word discards the word; the first sync = 0 cycle after release starts a new word.
- Throughput: one symbol per clock, sustained indefinitely.
- Latency: the last symbol is sampled at edge E. syndrome, err_detect and synd_valid = 1 are valid in the cycle after E (registered at E). synd_valid drops at E+1 unless another word also completes there, which requires N = 1 and is therefore impossible.
- busy is registered and equals (sym_cnt ≠ 0). It is 1 from the edge after the first symbol until the edge of the last symbol or the abort.
- Critical path: acc_j · constant (≤ 3-level XOR tree) ⊕ data_in, then the 8·TWO_T-input OR for err_detect. Both are single-cycle at the system clock.

## Test plan
- All-zero codeword: 255 cycles of sync = 0, data_in = 0x00. Required: synd_valid pulses once, one cycle after the 255th symbol; all 16 S_j = 0x00; err_detect = 0.
- Single error at the last position: 254 zeros then 0x01. Required: every S_j = 0x01; err_detect = 1.
- Single error at the first position: 0x01 then 254 zeros. Required: S_1 = α^254 = 0x8E, and generally S_j = α^(254·j mod 255); err_detect = 1.
- Valid encoder codeword (RS encoder output for a random 239-byte message), two words sent back-to-back with no gap. Required: two synd_valid pulses exactly 255 cycles apart; all syndromes 0 each time. Then flip 8 arbitrary bytes: err_detect = 1.
- Abort: sync = 1 after 100 symbols, then a full all-zero word. Required: no synd_valid for the partial word; busy falls after the abort edge; the next word produces a single synd_valid with all-zero syndromes. Prior syndrome/err_detect are held until then.
- Reset mid-word: assert sys_rst after 150 symbols, release, then send the single-error-at-last-position word. Required: all outputs 0 during reset; afterwards exactly one synd_valid with all S_j = 0x01.
